// File: rtl/sd_clk_div_pkg.sv
// Shared constants and types for the SD bus clock divider.
package sd_clk_div_pkg;

  localparam int unsigned DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t CNT_RST    = '0;
  localparam logic SD_CLK_RST = 1'b0;

endpackage

// File: rtl/sd_clk_divider.sv
// SD bus clock divider: SD_CLK period is 2*(DIVIDER+1) CLK cycles, 50% duty, driven from a flop.
// Optional edge strobes (SD_CLK_RISE_STB / SD_CLK_FALL_STB) are enabled by SD_CLK_DIV_EDGE_STB_EN.
module sd_clk_divider
  import sd_clk_div_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] DIVIDER,
`ifdef SD_CLK_DIV_EDGE_STB_EN
  output logic             SD_CLK_RISE_STB,
  output logic             SD_CLK_FALL_STB,
`endif
  output logic             SD_CLK
);

  div_t cnt_q;
  logic sd_clk_q;
  logic terminal;

  // Equality only: a DIVIDER below the running count forces a full wrap before the next toggle.
  assign terminal = (cnt_q == DIVIDER);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= CNT_RST;
      sd_clk_q <= SD_CLK_RST;
    end else if (terminal) begin
      cnt_q    <= CNT_RST;
      sd_clk_q <= ~sd_clk_q;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign SD_CLK = sd_clk_q;

`ifdef SD_CLK_DIV_EDGE_STB_EN
  logic rise_stb_q;
  logic fall_stb_q;

  // Registered alongside the toggle, so each pulse coincides with the first cycle of the new level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rise_stb_q <= 1'b0;
      fall_stb_q <= 1'b0;
    end else begin
      rise_stb_q <= terminal & ~sd_clk_q;
      fall_stb_q <= terminal & sd_clk_q;
    end
  end

  assign SD_CLK_RISE_STB = rise_stb_q;
  assign SD_CLK_FALL_STB = fall_stb_q;
`endif

endmodule

// File: tb/tb_sd_clk_divider.sv
// Scoreboard bench for sd_clk_divider: stimulus queues expected SD_CLK per cycle, monitor checks both edges.
module tb_sd_clk_divider;

  logic       CLK;
  logic       RST;
  logic [7:0] DIVIDER;
  logic       SD_CLK;
`ifdef SD_CLK_DIV_EDGE_STB_EN
  logic       SD_CLK_RISE_STB;
  logic       SD_CLK_FALL_STB;
`endif

  sd_clk_divider dut (
    .CLK             (CLK),
    .RST             (RST),
    .DIVIDER         (DIVIDER),
`ifdef SD_CLK_DIV_EDGE_STB_EN
    .SD_CLK_RISE_STB (SD_CLK_RISE_STB),
    .SD_CLK_FALL_STB (SD_CLK_FALL_STB),
`endif
    .SD_CLK          (SD_CLK)
  );

  typedef struct {
    logic  exp;
    string tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        checks = 0;
  int        errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: SD_CLK=%0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Each queued entry is the expected SD_CLK after the next rising edge; held through the falling edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, "_rise"}, SD_CLK, e.exp);
        @(negedge CLK);
        check({e.tag, "_fall"}, SD_CLK, e.exp);
      end
    end
  end

  task automatic next();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic e, input string t);
    sb_q.push_back('{exp: e, tag: t});
  endtask

  // k-th rising edge after release: SD_CLK is high in odd-numbered half-periods of d+1 edges.
  task automatic run_counts(input int d, input int n, input string t);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) next();
      push(((k / (d + 1)) % 2) == 1, t);
    end
  endtask

  task automatic reset_and_run(input int d, input int n, input string t);
    next();
    RST     = 1'b1;
    DIVIDER = 8'(d);
    push(1'b0, {t, "_in_rst"});
    next();
    push(1'b0, {t, "_in_rst"});
    next();
    RST = 1'b0;
    run_counts(d, n, t);
  endtask

  initial begin
    RST     = 1'b1;
    DIVIDER = 8'd0;
    #1;
    check("por_rst", SD_CLK, 1'b0);

    // CLK/2, rising on the first edge after release.
    reset_and_run(0, 8, "div0");

    // Period 8, first rise on the 4th edge.
    reset_and_run(3, 24, "div3");

    // Period 512, counter passes through 255 -> 0 twice.
    reset_and_run(255, 1100, "div255");

    // 10 -> 2 with cnt = 7: wrap through 255, toggle on edge 252, then period 6.
    reset_and_run(10, 7, "chg_pre");
    next();
    DIVIDER = 8'd2;
    for (int j = 1; j <= 270; j++) begin
      if (j > 1) next();
      push((j >= 252) && ((((j - 252) / 3) % 2) == 0), "chg_post");
    end

    // Async reset during the high phase, between CLK edges.
    reset_and_run(3, 6, "arst_pre");
    next();
    check("arst_high_before", SD_CLK, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_immediate", SD_CLK, 1'b0);
    push(1'b0, "arst_hold");
    next();
    push(1'b0, "arst_hold");
    next();
    RST = 1'b0;
    run_counts(3, 20, "arst_post");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) next();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: entries_left=%0d expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
